// File: rtl/hex_display_pkg.sv
// Shared constants, glyph table and scan-state encoding
// for the multiplexed hex display scanner.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, entry F first; segment a is bit 0
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GAP,
    ST_SHOW
  } scan_state_e;

endpackage

// File: rtl/hex_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational table lookup.
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = GLYPHS[nib];

endmodule

// File: rtl/hex_display_scanner.sv
// Scans one shared hex decoder across NUM_DIGITS digits
// with double-buffered value, dead-time gaps and blanking.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_GAP   = 2,
  parameter int LZ_BLANK    = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    KEY0,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   dig_mask,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [6:0]              SEG,
  output logic [NUM_DIGITS-1:0]   DIG_EN,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_GAP) ?
                        REFRESH_DIV : BLANK_GAP;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_GAP - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] pending_q, pending_d;
  logic pend_full_q, pend_full_d;
  logic ready_q, ready_d;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic fd_q, fd_d;

  logic slot_end;
  logic frame_end;
  logic accept;
  logic commit;
  logic lz_zero;
  logic blank;
  logic [3:0] dec_nib;
  logic [6:0] dec_seg;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q     <= ST_OFF;
      idx_q       <= '0;
      cnt_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      seg_q       <= SEG_BLANK;
      dig_en_q    <= '1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
      fd_q        <= fd_d;
    end
  end

  // Dropping en abandons the slot; no frame end is reported
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    slot_end = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_GAP;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d  = ST_GAP;
            cnt_d    = '0;
            slot_end = 1'b1;
            idx_d    = (idx_q == IDX_LAST) ?
                       '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign accept    = load_valid && ready_q;
  assign commit    = pend_full_q &&
                     (frame_end || state_q == ST_OFF);

  always_comb begin
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    if (accept) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end else if (commit) begin
      pend_full_d = 1'b0;
    end
    if (commit) active_d = pending_q;
    ready_d = !pend_full_d;
  end

  // Outputs follow the next state so they stay registered yet aligned
  always_comb begin
    lz_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_d) && active_d[4*j +: 4] != 4'h0)
        lz_zero = 1'b0;
    end
    blank = dig_mask[idx_d] ||
            (LZ_BLANK != 0 && idx_d != '0 && lz_zero);
  end

  assign dec_nib = active_d[{idx_d, 2'b00} +: 4];

  hex_seg_decoder u_dec (
    .nib (dec_nib),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d    = SEG_BLANK;
    dig_en_d = '1;
    fd_d     = frame_end;
    if (state_d == ST_SHOW && !blank) begin
      seg_d           = dec_seg;
      dig_en_d[idx_d] = 1'b0;
    end
  end

  assign load_ready = ready_q;
  assign SEG        = seg_q;
  assign DIG_EN     = dig_en_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: frame tables
// plus hand sequences for enable, buffering and reset.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        KEY0;
  logic        en;
  logic [3:0]  dig_mask;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [6:0]  SEG;
  logic [3:0]  DIG_EN;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
    logic [27:0] segs;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_GAP   (1),
    .LZ_BLANK    (1)
  ) dut (
    .CLOCK_50   (clk),
    .KEY0       (KEY0),
    .en         (en),
    .dig_mask   (dig_mask),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .SEG        (SEG),
    .DIG_EN     (DIG_EN),
    .frame_done (frame_done)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_assert++;
      if ($countones(~DIG_EN) > 1 ||
          (DIG_EN == 4'hF && SEG != 7'h7F)) begin
        n_fail++;
        $display("FAIL monitor: DIG_EN %b SEG %h",
                 DIG_EN, SEG);
      end
    end
  end

  task automatic wait_fd(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < lim);
    if (!frame_done) begin
      n_assert++;
      n_fail++;
      $display("FAIL fd_timeout: got none expected pulse");
    end
  endtask

  task automatic check_frame(input logic [27:0] e,
                             input logic rdy1);
    logic [6:0] es;
    logic [3:0] ed;
    int slot;
    int ph;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      slot = k / 5;
      ph   = k % 5;
      es   = e[slot*7 +: 7];
      ed   = 4'hF;
      if (ph == 0 || es == 7'h7F) begin
        es = 7'h7F;
      end else begin
        ed[slot] = 1'b0;
      end
      chk("frame_seg", 32'(SEG), 32'(es));
      chk("frame_dig", 32'(DIG_EN), 32'(ed));
      chk("frame_fd", 32'(frame_done), 32'(k == 0));
      if (k == 0) chk("frame_rdy0", 32'(load_ready), 1);
      if (k == 1) begin
        chk("frame_rdy1", 32'(load_ready), 32'(rdy1));
        load_valid = 1'b0;
      end
    end
  endtask

  task automatic offer(input logic [15:0] d);
    load_data  = d;
    load_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready_low", 32'(load_ready), 0);
    load_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic early_seg;
    logic early_rdy;

    vecs[0] = '{16'h1234, 4'b0000,
                {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h00A0, 4'b0000,
                {7'h7F, 7'h7F, 7'h08, 7'h40}};
    vecs[2] = '{16'h0000, 4'b0000,
                {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h8888, 4'b0100,
                {7'h00, 7'h7F, 7'h00, 7'h00}};
    vecs[4] = '{16'hFEDC, 4'b0000,
                {7'h0E, 7'h06, 7'h21, 7'h46}};
    vecs[5] = '{16'h0B09, 4'b0000,
                {7'h7F, 7'h03, 7'h40, 7'h10}};
    vecs[6] = '{16'h5670, 4'b0001,
                {7'h12, 7'h02, 7'h78, 7'h7F}};

    KEY0 = 1'b0;
    en = 1'b0;
    dig_mask = 4'h0;
    load_valid = 1'b0;
    load_data = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(SEG), 32'h7F);
    chk("rst_dig", 32'(DIG_EN), 32'hF);
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_fd", 32'(frame_done), 0);
    KEY0 = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // load while disabled commits straight away
    offer(vecs[0].data);
    @(negedge clk);
    chk("off_commit_ready", 32'(load_ready), 1);
    en = 1'b1;
    wait_fd(40, n);
    chk("first_frame_len", 32'(n), 21);
    check_frame(vecs[0].segs, 1'b1);

    for (int i = 1; i < 7; i++) begin
      dig_mask = vecs[i].mask;
      offer(vecs[i].data);
      wait_fd(45, n);
      check_frame(vecs[i].segs, 1'b1);
    end

    // mid-frame load, second offer held until commit
    dig_mask = 4'h0;
    wait_fd(5, n);
    chk("period", 32'(n), 1);
    repeat (7) @(negedge clk);
    load_data  = 16'h1111;
    load_valid = 1'b1;
    @(negedge clk);
    chk("mid_accept_ready", 32'(load_ready), 0);
    load_data = 16'h2222;
    early_seg = 1'b0;
    early_rdy = 1'b0;
    n = 0;
    while (!frame_done && n < 40) begin
      if (DIG_EN != 4'hF && SEG == 7'h79) early_seg = 1'b1;
      if (load_ready) early_rdy = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("no_early_show", 32'(early_seg), 0);
    chk("no_early_ready", 32'(early_rdy), 0);
    check_frame({4{7'h79}}, 1'b0);
    wait_fd(5, n);
    chk("period2", 32'(n), 1);
    check_frame({4{7'h24}}, 1'b1);

    // drop enable mid-slot of digit 2
    wait_fd(5, n);
    repeat (12) @(negedge clk);
    chk("pre_drop_dig", 32'(DIG_EN), 32'hB);
    en = 1'b0;
    @(negedge clk);
    chk("drop_seg", 32'(SEG), 32'h7F);
    chk("drop_dig", 32'(DIG_EN), 32'hF);
    repeat (3) @(negedge clk);
    chk("drop_fd", 32'(frame_done), 0);
    chk("drop_dark", 32'(DIG_EN), 32'hF);
    offer(16'h0B09);
    @(negedge clk);
    chk("drop_commit_ready", 32'(load_ready), 1);
    en = 1'b1;
    @(negedge clk);
    chk("rearm_gap", 32'(DIG_EN), 32'hF);
    @(negedge clk);
    chk("rearm_dig0", 32'(DIG_EN), 32'hE);
    chk("rearm_seg0", 32'(SEG), 32'h10);
    wait_fd(40, n);
    chk("rearm_frame_len", 32'(n), 19);
    check_frame(vecs[5].segs, 1'b1);

    // asynchronous reset in the middle of a lit slot
    wait_fd(5, n);
    @(negedge clk);
    load_data  = 16'h3333;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("pre_rst_ready", 32'(load_ready), 0);
    chk("pre_rst_dig", 32'(DIG_EN), 32'hE);
    #2;
    KEY0 = 1'b0;
    #1;
    chk("arst_seg", 32'(SEG), 32'h7F);
    chk("arst_dig", 32'(DIG_EN), 32'hF);
    chk("arst_ready", 32'(load_ready), 1);
    chk("arst_fd", 32'(frame_done), 0);
    @(negedge clk);
    KEY0 = 1'b1;
    wait_fd(40, n);
    chk("post_rst_len", 32'(n), 21);
    check_frame(vecs[2].segs, 1'b1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
